// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and the
// command codes driven onto the shift register's {LSH,RSH} control pair.
package shift_sequencer_pkg;

  // Controller states; IDLE must stay the all-zero encoding so that a
  // freshly reset register and the enum default agree.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Shift register command codes, bit 1 = LSH, bit 0 = RSH.
  // 2'b11 is illegal for the datapath and is never produced.
  localparam logic [1:0] SH_HOLD = 2'b00;
  localparam logic [1:0] SH_RSH  = 2'b01;
  localparam logic [1:0] SH_LSH  = 2'b10;

  // Direction encoding as carried on the request port.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller for an external single-step shift register.
// A request (operand, direction, amount) is accepted in IDLE, the register
// is loaded, then stepped one bit per cycle until the saturated amount is
// used up. The result is read straight from the register contents and is
// returned together with a sticky flag of every bit that fell off the end.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  input  logic [AMT_W-1:0] req_amt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_flag,
  output logic             busy,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_load,
  output logic [1:0]       sr_shift,
  input  logic [WIDTH-1:0] sr_out
);

  // The count must be able to hold WIDTH itself, otherwise saturation breaks.
  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

  state_t           state;
  logic [AMT_W-1:0] count;
  logic             dir;
  logic             flag;

  logic [AMT_W-1:0] amt_sat;
  logic             out_bit;
  logic             flag_next;

  // Saturate the requested amount and pick the bit about to be shifted out.
  // NOTE: every always_comb output gets a value on every path (here by
  // unconditional assignment); a missing branch would infer a latch.
  always_comb begin
    amt_sat   = (req_amt > AMT_MAX) ? AMT_MAX : req_amt;
    out_bit   = (dir == DIR_LEFT) ? sr_out[WIDTH-1] : sr_out[0];
    flag_next = flag | out_bit;
  end

  // Single FSM process: state, count, direction, sticky flag and all
  // control outputs are registered and change only on the clock edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      dir        <= 1'b0;
      flag       <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      sr_data    <= '0;
      sr_load    <= 1'b0;
      sr_shift   <= SH_HOLD;
      resp_valid <= 1'b0;
      resp_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            // Capture the whole request; the requester may change it freely
            // afterwards since nothing else is sampled until the next IDLE.
            sr_data   <= req_data;
            dir       <= req_dir;
            count     <= amt_sat;
            flag      <= 1'b0;
            sr_load   <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          // The register takes the operand on this edge; start stepping it
          // right away, or go straight to the response for a zero amount.
          sr_load <= 1'b0;
          if (count != '0) begin
            sr_shift <= (dir == DIR_LEFT) ? SH_LSH : SH_RSH;
            state    <= S_SHIFT;
          end else begin
            resp_valid <= 1'b1;
            resp_flag  <= flag;
            state      <= S_DONE;
          end
        end

        S_SHIFT: begin
          // The register moves on this same edge, so the bit leaving it is
          // the one visible on sr_out right now.
          flag <= flag_next;
          if (count != '0) begin
            count <= count - 1'b1;
          end
          if (count <= AMT_W'(1)) begin
            sr_shift   <= SH_HOLD;
            resp_valid <= 1'b1;
            resp_flag  <= flag_next;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          // Everything holds until the consumer takes the result.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_flag  <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state      <= S_IDLE;
          sr_load    <= 1'b0;
          sr_shift   <= SH_HOLD;
          resp_valid <= 1'b0;
          resp_flag  <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

  // The result is the live register contents, which hold while in DONE;
  // outside a response the port reads as zero.
  assign resp_data = resp_valid ? sr_out : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer. A behavioural single-step shift
// register closes the loop around the controller; expected results come from
// plain shift arithmetic on the original operand.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             req_dir;
  logic [AMT_W-1:0] req_amt;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_flag;
  logic             busy;
  logic [WIDTH-1:0] sr_data;
  logic             sr_load;
  logic [1:0]       sr_shift;
  logic [WIDTH-1:0] sr_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_dir    (req_dir),
    .req_amt    (req_amt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_flag  (resp_flag),
    .busy       (busy),
    .sr_data    (sr_data),
    .sr_load    (sr_load),
    .sr_shift   (sr_shift),
    .sr_out     (sr_out)
  );

  // Behavioural single-step shift register, zero fill on both sides.
  logic [WIDTH-1:0] sr_q;
  assign sr_out = sr_q;
  always @(posedge clk) begin
    if (sr_load)                 sr_q <= sr_data;
    else if (sr_shift == 2'b10)  sr_q <= sr_q << 1;
    else if (sr_shift == 2'b01)  sr_q <= sr_q >> 1;
  end

  // Expected result and flag from whole-word arithmetic.
  function automatic void model(input int data, input int dir, input int n,
                                output int res, output int flg);
    int full;
    if (dir == 0) begin
      full = data << n;
      res  = full & ((1 << WIDTH) - 1);
      flg  = ((full >> WIDTH) != 0) ? 1 : 0;
    end else begin
      res = data >> n;
      flg = ((data & ((1 << n) - 1)) != 0) ? 1 : 0;
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset      = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete transaction with protocol and result checks.
  task automatic run_op(input logic [WIDTH-1:0] data, input logic dir,
                        input logic [AMT_W-1:0] amt, input int hold,
                        input bit keep_valid, input string tag);
    int n, exp_res, exp_flag, lat, shifts, loads;
    bit seen;
    logic [1:0] code;
    n    = (int'(amt) > WIDTH) ? WIDTH : int'(amt);
    code = dir ? 2'b01 : 2'b10;
    model(int'(data), int'(dir), n, exp_res, exp_flag);

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept got=%b want=1", tag, req_ready);
    end
    req_valid = 1'b1;
    req_data  = data;
    req_dir   = dir;
    req_amt   = amt;
    @(posedge clk);

    lat = 0; shifts = 0; loads = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) begin
        seen = 1;
        break;
      end
      checks++;
      if ({req_ready, busy} !== 2'b01 || (sr_load && sr_shift != 2'b00) ||
          (sr_shift != 2'b00 && sr_shift != code)) begin
        failures++;
        $display("FAIL %s busy_ctrl cyc=%0d ready=%b busy=%b load=%b shift=%b want_shift=%b",
                 tag, lat, req_ready, busy, sr_load, sr_shift, code);
      end
      if (sr_load === 1'b1) begin
        loads++;
        checks++;
        if (lat != 1 || sr_data !== data) begin
          failures++;
          $display("FAIL %s load cyc=%0d sr_data=%h want cyc=1 data=%h", tag, lat, sr_data, data);
        end
      end
      if (sr_shift === code) shifts++;
      if (keep_valid) begin
        req_data = WIDTH'($urandom);
        req_dir  = 1'($urandom);
        req_amt  = AMT_W'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end

    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s resp_timeout got=no_resp want=resp_after_%0d", tag, n + 2);
      apply_reset();
      return;
    end
    checks++;
    if (lat != n + 2 || shifts != n || loads != 1) begin
      failures++;
      $display("FAIL %s timing lat=%0d shifts=%0d loads=%0d want lat=%0d shifts=%0d loads=1",
               tag, lat, shifts, loads, n + 2, n);
    end
    checks++;
    if (resp_data !== WIDTH'(exp_res) || resp_flag !== 1'(exp_flag)) begin
      failures++;
      $display("FAIL %s result got=%b/%b want=%b/%0d", tag, resp_data, resp_flag,
               WIDTH'(exp_res), exp_flag);
    end

    // Stall the consumer; the response must not move.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_data, resp_flag, req_ready, busy, sr_shift, sr_load} !==
          {1'b1, WIDTH'(exp_res), 1'(exp_flag), 1'b0, 1'b1, 2'b00, 1'b0}) begin
        failures++;
        $display("FAIL %s hold cyc=%0d valid=%b data=%b flag=%b ready=%b busy=%b shift=%b load=%b want 1 %b %0d 0 1 00 0",
                 tag, i, resp_valid, resp_data, resp_flag, req_ready, busy, sr_shift,
                 sr_load, WIDTH'(exp_res), exp_flag);
      end
      if (keep_valid) req_data = WIDTH'($urandom);
    end

    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL %s release ready=%b busy=%b valid=%b want 1 0 0", tag, req_ready, busy,
               resp_valid);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_flag, busy, sr_data, sr_load, sr_shift} !==
        {1'b1, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL %s reset_vals ready=%b valid=%b data=%b flag=%b busy=%b sr_data=%b load=%b shift=%b want 1 0 0 0 0 0 0 00",
               tag, req_ready, resp_valid, resp_data, resp_flag, busy, sr_data, sr_load,
               sr_shift);
    end
  endtask

  task automatic test_reset();
    // Reset must win even with a request pending.
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_data  = 4'b1111;
    req_amt   = 3'd2;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check_reset_values("reset_idle");
  endtask

  task automatic test_directed();
    run_op(4'b0010, 1'b1, 3'd1, 0, 1'b0, "rsh1");
    run_op(4'b0010, 1'b1, 3'd2, 0, 1'b0, "rsh2");
    run_op(4'b1011, 1'b0, 3'd1, 1, 1'b0, "lsh1");
    run_op(4'b1111, 1'b0, 3'd5, 0, 1'b0, "lsh5_sat");
    run_op(4'b1001, 1'b1, 3'd7, 0, 1'b0, "rsh7_sat");
    run_op(4'b1010, 1'b0, 3'd0, 0, 1'b0, "amt0");
    run_op(4'b0110, 1'b1, 3'd4, 0, 1'b0, "rsh4");
  endtask

  task automatic test_stall();
    run_op(4'b1101, 1'b1, 3'd3, 5, 1'b0, "stall5");
  endtask

  task automatic test_busy_ignore();
    // Request stays asserted with changing contents throughout the op.
    run_op(4'b0101, 1'b0, 3'd2, 2, 1'b1, "busy_ignore");
    run_op(4'b1000, 1'b1, 3'd0, 1, 1'b1, "busy_ignore0");
  endtask

  task automatic test_abort();
    bit hit;
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 4'b0111;
    req_dir   = 1'b0;
    req_amt   = 3'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      if (sr_shift === 2'b10) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort no_shift_seen got=%b want=10", sr_shift);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("abort");
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) hit = 1;
    end
    checks++;
    if (hit) begin
      failures++;
      $display("FAIL abort stray_resp got=activity want=idle");
    end
    run_op(4'b0001, 1'b0, 3'd1, 0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(WIDTH'($urandom), 1'($urandom), AMT_W'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_data   = '0;
    req_dir    = 1'b0;
    req_amt    = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_busy_ignore();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
